spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
- Command/register-access layer directly downstream of the SPI slave byte engine.
- Consumes received bytes (rx_valid/rx_byte), parses frames delimited by cs, and issues 16-bit register writes and reads to FPGA fabric logic.
- Supplies the next transmit byte (tx_byte) back to the SPI slave data_tx input, so the MCU can read registers.
- Frame: byte0 = command {rw, addr[6:0]} (rw=1 read, rw=0 write), then big-endian 16-bit data pairs with address auto-increment.

Parameters:
ADDR_W, 7, register address width; must be ≤ 7 (command byte carries the address in bits 6:0).
IDLE_TX, 8'hA5, byte presented on tx_byte while idle or during the command byte.
CS_SYNC, 1, 1 = cs passes through a 2-flop synchronizer; 0 = cs is already in the sys_clk domain.

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset; asynchronous, active-low
cs  in  1  SPI chip select, active-low; frame delimiter
rx_valid  in  1  one-cycle pulse from the SPI slave: rx_byte is complete
rx_byte  in  8  received byte
tx_byte  out  8  byte the slave shifts out next
reg_wr_en  out  1  one-cycle write strobe
reg_wr_addr  out  ADDR_W  write address
reg_wr_data  out  16  write data
reg_rd_addr  out  ADDR_W  read address; fabric returns reg_rd_data combinationally
reg_rd_data  in  16  read data
frame_err  out  1  one-cycle pulse: frame ended on an odd data byte
busy  out  1  high while a frame is open (cs low)

Behaviour:
- Clock and reset: sys_clk; reset sys_rst_n, asynchronous, active-low.
- Reset values: state = IDLE, tx_byte = IDLE_TX, reg_wr_en = 0, reg_wr_addr = 0, reg_wr_data = 0, reg_rd_addr = 0, frame_err = 0, busy = 0; address counter, rw flag, hi-byte and read buffers = 0.
- Chip select: cs_l is the synchronized cs (CS_SYNC=1 adds 2 cycles of latency). The fall and rise of cs_l are detected as one-cycle events.
- States: IDLE, CMD, DATA_HI, DATA_LO.
  - IDLE → CMD on cs_l fall. busy = 1 from that cycle.
  - CMD, on rx_valid: latch rw = rx_byte[7] and addr = rx_byte[ADDR_W-1:0]; go to DATA_HI.
  - DATA_HI, on rx_valid: go to DATA_LO.
  - DATA_LO, on rx_valid: go to DATA_HI; addr increments modulo 2^ADDR_W (127 → 0).
  - Any state → IDLE on cs_l rise. busy = 0 and tx_byte = IDLE_TX on the next cycle.
- rx_valid while in IDLE is ignored. A cs_l rise in the same cycle as rx_valid takes priority; that byte is discarded.
- Write path (rw=0):
  - DATA_HI rx_valid: hi_byte <= rx_byte.
  - DATA_LO rx_valid: on the next cycle reg_wr_en = 1 for exactly one cycle, with reg_wr_addr = current addr and reg_wr_data = {hi_byte, rx_byte}; addr increments in the same cycle.
- Read path (rw=1):
  - reg_rd_addr always tracks addr.
  - One cycle after the command is latched, rd_buf <= reg_rd_data and tx_byte <= rd_buf-hi (the captured [15:8]).
  - DATA_HI rx_valid: tx_byte <= rd_buf[7:0] the next cycle.
  - DATA_LO rx_valid: addr++; one cycle later rd_buf is recaptured from the new address and tx_byte <= new [15:8].
  - No writes are issued during read frames.
- tx_byte update latency: ≤ 2 sys_clk after rx_valid. The master's inter-byte gap must be ≥ 4 sys_clk plus synchronizer delay. This is a documented system constraint, not checked in RTL.
- In write frames, tx_byte = IDLE_TX throughout.
- cs_l rise while in DATA_LO:
  - frame_err = 1 for one cycle.
  - The pending hi byte is discarded; no write is issued.
- cs_l rise while in CMD or DATA_HI is a clean frame end with no error. A frame with zero data bytes is legal.
- Asynchronous reset mid-frame: all state is immediately reset; no partial write is emitted.

Decomposition:
- Package spi_frame_pkg holds:
  - the state encoding localparams (IDLE=2'd0, CMD=2'd1, DATA_HI=2'd2, DATA_LO=2'd3);
  - CMD_RW_BIT=7;
  - the default IDLE_TX.
- Sub-module cs_sync_edge: optional 2-flop synchronizer, fall/rise pulse generation, reset to cs_l = 1.

Test Plan:
1. Single write: cs low; bytes 0x05, 0x12, 0x34; cs high → exactly one reg_wr_en pulse with addr 5, data 0x1234; frame_err = 0.
2. Burst write with wrap: cmd 0x7F, then 0xAA, 0xBB, 0xCC, 0xDD → writes (127, 0xAABB) then (0, 0xCCDD).
3. Read: model returns reg[addr] = addr*0x0101; cmd 0x83 followed by 4 dummy bytes → tx_byte sequence 0x03, 0x03, 0x04, 0x04; never any reg_wr_en.
4. Odd frame: cmd 0x02, then 0x11; cs high → frame_err pulse, no write, busy falls, tx_byte = 0xA5.
5. Reset mid-frame: assert sys_rst_n low between the hi and lo data bytes → all outputs return to reset values; the next frame (cmd 0x01, 0x00, 0x01) writes (1, 0x0001).
6. Noise: rx_valid pulses while cs high → no state change; rx_valid coincident with the cs_l rise → byte discarded.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared frame-layer definitions for the SPI register bridge.
package spi_frame_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 16;

    // Frame parser state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CMD     = 2'd1;
    localparam logic [1:0] ST_DATA_HI = 2'd2;
    localparam logic [1:0] ST_DATA_LO = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        CMD     = ST_CMD,
        DATA_HI = ST_DATA_HI,
        DATA_LO = ST_DATA_LO
    } frame_state_e;

    // Command byte: bit 7 selects read (1) or write (0), low bits carry the address
    localparam int unsigned CMD_RW_BIT = 7;

    // Filler byte shifted out when no read data is pending
    localparam logic [BYTE_W-1:0] IDLE_TX_DEFAULT = 8'hA5;

endpackage

// File: rtl/cs_sync_edge.sv
// Chip-select conditioning: optional 2-flop synchronizer plus fall/rise pulses.
module cs_sync_edge #(
    parameter bit CS_SYNC = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic cs,
    output logic cs_l,
    output logic fall_c,
    output logic rise_c
);

    logic cs_prev_q;
    logic cs_prev_d;

    generate
        if (CS_SYNC) begin : g_sync
            logic meta_q;
            logic meta_d;
            logic sync_q;
            logic sync_d;

            // Two-stage capture of the asynchronous chip select
            always_comb begin
                meta_d = cs;
                sync_d = meta_q;
            end

            // Synchronizer flops idle high (deselected)
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    meta_q <= 1'b1;
                    sync_q <= 1'b1;
                end else begin
                    meta_q <= meta_d;
                    sync_q <= sync_d;
                end
            end

            assign cs_l = sync_q;
        end else begin : g_direct
            assign cs_l = cs;
        end
    endgenerate

    // Previous cs_l level for edge detection
    always_comb begin
        cs_prev_d = cs_l;
    end

    // Edge-detect history register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cs_prev_q <= 1'b1;
        end else begin
            cs_prev_q <= cs_prev_d;
        end
    end

    assign fall_c = cs_prev_q & ~cs_l;
    assign rise_c = ~cs_prev_q & cs_l;

endmodule

// File: rtl/spi_reg_bridge.sv
// Parses SPI byte frames into 16-bit register writes/reads and feeds read data back to the slave.
module spi_reg_bridge
    import spi_frame_pkg::*;
#(
    parameter int unsigned        ADDR_W  = 7,
    parameter logic [BYTE_W-1:0]  IDLE_TX = IDLE_TX_DEFAULT,
    parameter bit                 CS_SYNC = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                cs,
    input  logic                rx_valid,
    input  logic [BYTE_W-1:0]   rx_byte,
    output logic [BYTE_W-1:0]   tx_byte,
    output logic                reg_wr_en,
    output logic [ADDR_W-1:0]   reg_wr_addr,
    output logic [DATA_W-1:0]   reg_wr_data,
    output logic [ADDR_W-1:0]   reg_rd_addr,
    input  logic [DATA_W-1:0]   reg_rd_data,
    output logic                frame_err,
    output logic                busy
);

    logic cs_l;
    logic cs_fall_c;
    logic cs_rise_c;

    frame_state_e        state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic                rw_q,        rw_d;
    logic [BYTE_W-1:0]   hi_q,        hi_d;
    logic [BYTE_W-1:0]   rd_lo_q,     rd_lo_d;
    logic                rd_load_q,   rd_load_d;
    logic [BYTE_W-1:0]   tx_byte_q,   tx_byte_d;
    logic                wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q,   wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q,   wr_data_d;
    logic                frame_err_q, frame_err_d;
    logic                busy_q,      busy_d;

    cs_sync_edge #(
        .CS_SYNC (CS_SYNC)
    ) u_cs_sync_edge (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cs        (cs),
        .cs_l      (cs_l),
        .fall_c    (cs_fall_c),
        .rise_c    (cs_rise_c)
    );

    // Frame parser: next state, address sequencing, write strobes and tx byte selection
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        hi_d        = hi_q;
        rd_lo_d     = rd_lo_q;
        rd_load_d   = 1'b0;
        tx_byte_d   = tx_byte_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        busy_d      = busy_q;

        // High byte goes straight to tx; only the low byte needs holding for the next slot
        if (rd_load_q) begin
            rd_lo_d   = reg_rd_data[BYTE_W-1:0];
            tx_byte_d = reg_rd_data[DATA_W-1:BYTE_W];
        end

        if (cs_rise_c) begin
            // Frame end wins over a coincident byte, which is dropped
            state_d     = IDLE;
            busy_d      = 1'b0;
            tx_byte_d   = IDLE_TX;
            rd_load_d   = 1'b0;
            frame_err_d = (state_q == DATA_LO);
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall_c) begin
                        state_d   = CMD;
                        busy_d    = 1'b1;
                        tx_byte_d = IDLE_TX;
                    end
                end
                CMD: begin
                    if (rx_valid) begin
                        rw_d      = rx_byte[CMD_RW_BIT];
                        addr_d    = rx_byte[ADDR_W-1:0];
                        rd_load_d = rx_byte[CMD_RW_BIT];
                        state_d   = DATA_HI;
                    end
                end
                DATA_HI: begin
                    if (rx_valid) begin
                        state_d = DATA_LO;
                        if (rw_q) begin
                            tx_byte_d = rd_lo_q;
                        end else begin
                            hi_d = rx_byte;
                        end
                    end
                end
                DATA_LO: begin
                    if (rx_valid) begin
                        state_d = DATA_HI;
                        addr_d  = addr_q + ADDR_W'(1);
                        if (rw_q) begin
                            rd_load_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = {hi_q, rx_byte};
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            hi_q        <= '0;
            rd_lo_q     <= '0;
            rd_load_q   <= 1'b0;
            tx_byte_q   <= IDLE_TX;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            hi_q        <= hi_d;
            rd_lo_q     <= rd_lo_d;
            rd_load_q   <= rd_load_d;
            tx_byte_q   <= tx_byte_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_byte     = tx_byte_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign reg_rd_addr = addr_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: directed frames plus randomized frames vs a frame-level model.
module tb_spi_reg_bridge;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        cs;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic        reg_wr_en;
    logic [6:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;
    logic [6:0]  reg_rd_addr;
    logic [15:0] reg_rd_data;
    logic        frame_err;
    logic        busy;

    int n_total;
    int n_bad;

    // Fabric read model: reg[a] = a*0x0101, optionally scrambled by a per-test salt
    logic [15:0] rd_salt;

    function automatic logic [15:0] rd_model(input logic [6:0] a);
        logic [15:0] w;
        w = 16'({9'd0, a}) * 16'h0101;
        return w ^ rd_salt;
    endfunction

    assign reg_rd_data = rd_model(reg_rd_addr);

    spi_reg_bridge #(
        .ADDR_W  (7),
        .IDLE_TX (8'hA5),
        .CS_SYNC (1'b1)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cs          (cs),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .tx_byte     (tx_byte),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Observed traffic, sampled on the falling edge
    logic [6:0]  got_wa[$];
    logic [15:0] got_wd[$];
    int          got_err;

    always @(negedge sys_clk) begin
        if (reg_wr_en === 1'b1) begin
            got_wa.push_back(reg_wr_addr);
            got_wd.push_back(reg_wr_data);
        end
        if (frame_err === 1'b1) got_err = got_err + 1;
    end

    // Frame under test, its expected results, and per-byte observations
    logic [7:0]  frame_q[$];
    logic [6:0]  exp_wa[$];
    logic [15:0] exp_wd[$];
    logic [7:0]  exp_tx[$];
    int          exp_err;
    logic [7:0]  obs_tx[$];
    logic        obs_busy[$];

    // Frame-level reference: what a whole frame should produce
    task automatic model_frame();
        logic [7:0]  cmd;
        logic [6:0]  a;
        logic [6:0]  wa;
        logic [15:0] word;
        int          n;
        exp_wa.delete();
        exp_wd.delete();
        exp_tx.delete();
        exp_err = 0;
        if (frame_q.size() == 0) return;
        cmd = frame_q[0];
        a   = cmd[6:0];
        n   = frame_q.size() - 1;
        if (cmd[7] == 1'b0) begin
            for (int k = 0; k < n / 2; k++) begin
                wa = a + 7'(k);
                exp_wa.push_back(wa);
                exp_wd.push_back({frame_q[1 + 2*k], frame_q[2 + 2*k]});
            end
        end
        exp_err = n % 2;
        // tx after byte i is the byte for slot i+1: word a + i/2, high half on even i
        for (int i = 0; i <= n; i++) begin
            if (cmd[7] == 1'b0) begin
                exp_tx.push_back(8'hA5);
            end else begin
                wa   = a + 7'(i / 2);
                word = rd_model(wa);
                exp_tx.push_back((i % 2 == 0) ? word[15:8] : word[7:0]);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // One byte from the SPI slave followed by a legal inter-byte gap
    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        idle(5);
    endtask

    task automatic run_frame();
        got_wa.delete();
        got_wd.delete();
        got_err = 0;
        obs_tx.delete();
        obs_busy.delete();
        @(negedge sys_clk);
        cs = 1'b0;
        idle(4);
        foreach (frame_q[i]) begin
            send_byte(frame_q[i]);
            obs_tx.push_back(tx_byte);
            obs_busy.push_back(busy);
        end
        cs = 1'b1;
        idle(6);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        cs        = 1'b1;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        rd_salt   = 16'h0000;
        got_err   = 0;
        idle(3);
        n_total++; if (tx_byte !== 8'hA5) begin n_bad++; $display("FAIL reset_tx: got %h want a5", tx_byte); end
        n_total++; if (reg_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", reg_wr_en); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_total++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_total++; if ({reg_wr_addr, reg_wr_data, reg_rd_addr} !== 30'd0) begin n_bad++; $display("FAIL reset_addr_data: got %h/%h/%h want 0", reg_wr_addr, reg_wr_data, reg_rd_addr); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(3);
        n_total++; if (busy !== 1'b0 || tx_byte !== 8'hA5) begin n_bad++; $display("FAIL post_reset_idle: got busy=%b tx=%h want 0/a5", busy, tx_byte); end
    endtask

    // Single write and a burst that wraps the address from 127 to 0
    task automatic test_write();
        for (int f = 0; f < 2; f++) begin
            if (f == 0) frame_q = {8'h05, 8'h12, 8'h34};
            else        frame_q = {8'h7F, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
            model_frame();
            run_frame();
            n_total++; if (got_wa.size() != exp_wa.size()) begin n_bad++; $display("FAIL write_count f%0d: got %0d want %0d", f, got_wa.size(), exp_wa.size()); end
            for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
                n_total++; if (got_wa[i] !== exp_wa[i] || got_wd[i] !== exp_wd[i]) begin n_bad++; $display("FAIL write_%0d f%0d: got (%0d,%h) want (%0d,%h)", i, f, got_wa[i], got_wd[i], exp_wa[i], exp_wd[i]); end
            end
            n_total++; if (got_err != exp_err) begin n_bad++; $display("FAIL write_err f%0d: got %0d want %0d", f, got_err, exp_err); end
            for (int i = 0; i < exp_tx.size(); i++) begin
                n_total++; if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== 1'b1) begin n_bad++; $display("FAIL write_tx_busy_%0d f%0d: got %h/%b want %h/1", i, f, obs_tx[i], obs_busy[i], exp_tx[i]); end
            end
            n_total++; if (busy !== 1'b0 || tx_byte !== 8'hA5) begin n_bad++; $display("FAIL write_end f%0d: got busy=%b tx=%h want 0/a5", f, busy, tx_byte); end
        end
    endtask

    task automatic test_read();
        rd_salt = 16'h0000;
        frame_q = {8'h83, 8'h00, 8'hFF, 8'h5A, 8'hC3};
        model_frame();
        run_frame();
        for (int i = 0; i < exp_tx.size(); i++) begin
            n_total++; if (obs_tx[i] !== exp_tx[i]) begin n_bad++; $display("FAIL read_tx_%0d: got %h want %h", i, obs_tx[i], exp_tx[i]); end
        end
        n_total++; if (got_wa.size() != 0) begin n_bad++; $display("FAIL read_no_write: got %0d writes want 0", got_wa.size()); end
        n_total++; if (got_err != 0 || busy !== 1'b0 || tx_byte !== 8'hA5) begin n_bad++; $display("FAIL read_end: got err=%0d busy=%b tx=%h want 0/0/a5", got_err, busy, tx_byte); end
    endtask

    task automatic test_odd_frame();
        frame_q = {8'h02, 8'h11};
        model_frame();
        run_frame();
        n_total++; if (got_err != exp_err) begin n_bad++; $display("FAIL odd_err: got %0d want %0d", got_err, exp_err); end
        n_total++; if (got_wa.size() != 0) begin n_bad++; $display("FAIL odd_no_write: got %0d writes want 0", got_wa.size()); end
        n_total++; if (busy !== 1'b0 || tx_byte !== 8'hA5) begin n_bad++; $display("FAIL odd_end: got busy=%b tx=%h want 0/a5", busy, tx_byte); end
    endtask

    task automatic test_reset_mid_frame();
        got_wa.delete();
        got_wd.delete();
        got_err = 0;
        @(negedge sys_clk);
        cs = 1'b0;
        idle(4);
        send_byte(8'h10);
        send_byte(8'h55);
        sys_rst_n = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0 || tx_byte !== 8'hA5 || reg_wr_en !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("FAIL midrst_outputs: got busy=%b tx=%h wr=%b err=%b want 0/a5/0/0", busy, tx_byte, reg_wr_en, frame_err); end
        n_total++; if ({reg_wr_addr, reg_wr_data, reg_rd_addr} !== 30'd0) begin n_bad++; $display("FAIL midrst_regs: got %h/%h/%h want 0", reg_wr_addr, reg_wr_data, reg_rd_addr); end
        cs = 1'b1;
        idle(3);
        sys_rst_n = 1'b1;
        send_byte(8'h66);
        idle(4);
        n_total++; if (got_wa.size() != 0 || got_err != 0) begin n_bad++; $display("FAIL midrst_no_partial: got %0d writes err=%0d want 0/0", got_wa.size(), got_err); end
        frame_q = {8'h01, 8'h00, 8'h01};
        model_frame();
        run_frame();
        n_total++; if (got_wa.size() != 1 || got_wa[0] !== 7'd1 || got_wd[0] !== 16'h0001) begin n_bad++; $display("FAIL midrst_next_frame: got n=%0d (%0d,%h) want n=1 (1,0001)", got_wa.size(), (got_wa.size() > 0) ? got_wa[0] : 7'd0, (got_wd.size() > 0) ? got_wd[0] : 16'd0); end
    endtask

    task automatic test_noise();
        got_wa.delete();
        got_wd.delete();
        got_err = 0;
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        n_total++; if (got_wa.size() != 0 || busy !== 1'b0 || tx_byte !== 8'hA5) begin n_bad++; $display("FAIL noise_idle: got writes=%0d busy=%b tx=%h want 0/0/a5", got_wa.size(), busy, tx_byte); end
        // Last data byte lands in the same cycle as the cs_l rise
        @(negedge sys_clk);
        cs = 1'b0;
        idle(4);
        send_byte(8'h20);
        send_byte(8'h12);
        cs = 1'b1;
        idle(2);
        rx_valid = 1'b1;
        rx_byte  = 8'h34;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        idle(6);
        n_total++; if (got_wa.size() != 0) begin n_bad++; $display("FAIL coincident_discard: got %0d writes want 0", got_wa.size()); end
        n_total++; if (got_err != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL coincident_err: got err=%0d busy=%b want 1/0", got_err, busy); end
    endtask

    task automatic test_random();
        int len;
        for (int f = 0; f < 10; f++) begin
            rd_salt = 16'($urandom);
            len = $urandom_range(0, 6);
            frame_q.delete();
            frame_q.push_back(8'($urandom));
            for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
            model_frame();
            run_frame();
            n_total++; if (got_wa.size() != exp_wa.size()) begin n_bad++; $display("FAIL rnd_write_count f%0d: got %0d want %0d", f, got_wa.size(), exp_wa.size()); end
            for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
                n_total++; if (got_wa[i] !== exp_wa[i] || got_wd[i] !== exp_wd[i]) begin n_bad++; $display("FAIL rnd_write_%0d f%0d: got (%0d,%h) want (%0d,%h)", i, f, got_wa[i], got_wd[i], exp_wa[i], exp_wd[i]); end
            end
            for (int i = 0; i < exp_tx.size(); i++) begin
                n_total++; if (obs_tx[i] !== exp_tx[i]) begin n_bad++; $display("FAIL rnd_tx_%0d f%0d: got %h want %h", i, f, obs_tx[i], exp_tx[i]); end
            end
            n_total++; if (got_err != exp_err || busy !== 1'b0) begin n_bad++; $display("FAIL rnd_end f%0d: got err=%0d busy=%b want %0d/0", f, got_err, busy, exp_err); end
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_write();
        test_read();
        test_odd_frame();
        test_reset_mid_frame();
        test_noise();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
